seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider; the inverse arithmetic operation of the ripple-carry add/sub datapath.
- Computes quotient and remainder of WIDTH-bit operands using one restoring shift-subtract step per clock.
- Each step reuses a combinational add/sub stage: B inverted and carry-in forced to 1 in subtract mode.
- Sits beside the adder in the ALU project as the DIV/MOD functional unit, driven by a start/done handshake.

---
 rtl/div_pkg.sv | 14 +
 rtl/addsub_stage.sv | 17 +
 rtl/seq_restoring_divider.sv | 146 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential restoring divider
package div_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } div_state_t;

endpackage

// File: rtl/addsub_stage.sv
// rtl/addsub_stage.sv - combinational W-bit adder/subtractor; mode=1 computes a - b
module addsub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] b_eff;

    assign b_eff        = mode ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, mode};

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring divider; DIVIDER_SIGNED_EN adds signed operands
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state, state_nx;
    logic [WIDTH:0]   r, r_sh, r_nx, trial;
    logic [WIDTH-1:0] q, q_nx, d;
    logic [CW-1:0]    cnt;
    logic             trial_co, fits, zero_div;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign zero_div = (divisor == '0);
    assign r_sh     = {r[WIDTH-1:0], q[WIDTH-1]};

    addsub_stage #(.W(WIDTH + 1)) u_trial (
        .a    (r_sh),
        .b    ({1'b0, d}),
        .mode (1'b1),
        .sum  (trial),
        .carry(trial_co)
    );

    // carry-out and the cleared MSB both mean the subtraction did not borrow
    assign fits = ~trial[WIDTH] & trial_co;
    assign r_nx = fits ? trial : r_sh;
    assign q_nx = {q[WIDTH-2:0], fits};

`ifdef DIVIDER_SIGNED_EN
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] nq, nr;
    logic [1:0]       neg_co;

    assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;

    addsub_stage #(.W(WIDTH)) u_neg_q (
        .a('0), .b(q), .mode(1'b1), .sum(nq), .carry(neg_co[0])
    );
    addsub_stage #(.W(WIDTH)) u_neg_r (
        .a('0), .b(r[WIDTH-1:0]), .mode(1'b1), .sum(nr), .carry(neg_co[1])
    );
`else
    assign mag_a = dividend;
    assign mag_b = divisor;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = zero_div ? DONE : RUN;
            RUN: begin
                if (cnt == '0) begin
`ifdef DIVIDER_SIGNED_EN
                    state_nx = FIXUP;
`else
                    state_nx = DONE;
`endif
                end
            end
            FIXUP: state_nx = DONE;
            DONE:  state_nx = start ? (zero_div ? DONE : RUN) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && zero_div) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        r           <= '0;
                        q           <= mag_a;
                        d           <= mag_b;
                        cnt         <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt - 1'b1;
`ifndef DIVIDER_SIGNED_EN
                    if (cnt == '0) begin
                        quotient  <= q_nx;
                        remainder <= r_nx[WIDTH-1:0];
                    end
`endif
                end
`ifdef DIVIDER_SIGNED_EN
                FIXUP: begin
                    quotient  <= neg_q ? nq : q;
                    remainder <= neg_r ? nr : r[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench against an arithmetic reference
module tb_seq_restoring_divider;

    localparam int W = 4;
`ifdef DIVIDER_SIGNED_EN
    localparam int EXTRA = 1;
    localparam bit SGN   = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam bit SGN   = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        int sa, sb, tq, tr;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            if (SGN) begin
                sa = $signed(a); sb = $signed(b);
            end else begin
                sa = int'(a); sb = int'(b);
            end
            tq = sa / sb;
            tr = sa % sb;
            q = tq[W-1:0]; r = tr[W-1:0]; z = 1'b0; lat = W + 1 + EXTRA;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hammer, input bit from_done, input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        int           elat, n;
        bit           overlap;
        model(a, b, eq, er, ez, elat);
        if (!from_done) @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        n = 1; overlap = 1'b0;
        start = hammer ? busy : 1'b0;
        if (hammer) begin dividend = W'($urandom); divisor = W'($urandom); end
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (busy && done) overlap = 1'b1;
            if (hammer) begin
                start = busy; dividend = W'($urandom); divisor = W'($urandom);
            end
        end
        start = 1'b0;
        check({tag, ".lat"}, n, elat);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, div_by_zero, ez);
        check({tag, ".overlap"}, overlap, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        int           elat;

        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dbz", div_by_zero, 0);
        @(negedge clk) rst = 1'b0;

        run_op(4'd13, 4'd3, 1'b0, 1'b0, "d13_3");
        run_op(4'd15, 4'd1, 1'b0, 1'b0, "d15_1");
        run_op(4'd2,  4'd9, 1'b0, 1'b0, "d2_9");
        run_op(4'd7,  4'd0, 1'b0, 1'b0, "d7_0");
        run_op(4'd6,  4'd2, 1'b0, 1'b0, "d6_2");
        run_op(4'd9,  4'd4, 1'b1, 1'b0, "hammer9_4");
        run_op(4'd10, 4'd3, 1'b0, 1'b1, "b2b10_3");
        run_op(4'd5,  4'd0, 1'b0, 1'b1, "b2b5_0");

        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst.busy", busy, 0);
        check("arst.done", done, 0);
        check("arst.q", quotient, 0);
        check("arst.r", remainder, 0);
        check("arst.dbz", div_by_zero, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("arst.nodone", done, 0);
        end
        @(negedge clk) rst = 1'b0;
        run_op(4'd12, 4'd5, 1'b0, 1'b0, "d12_5");

`ifdef DIVIDER_SIGNED_EN
        run_op(4'b1001, 4'd2, 1'b0, 1'b0, "sm7_2");
        run_op(4'd7, 4'b1110, 1'b0, 1'b0, "s7_m2");
        run_op(4'b1000, 4'b1111, 1'b0, 1'b0, "sm8_m1");
`endif

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
            run_op(a, b, 1'b0, 1'b0, "rnd");
            model(a, b, eq, er, ez, elat);
            @(posedge clk); #1;
            check("rnd.idle_done", done, 0);
            check("rnd.hold_q", quotient, eq);
            check("rnd.hold_r", remainder, er);
            check("rnd.hold_dbz", div_by_zero, ez);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
